// File: rtl/shift_issue_queue_pkg.sv
// rtl/shift_issue_queue_pkg.sv - shared widths and field layouts for the shift issue path
// Dispatch, this queue and the shift unit all pack through these structs.
package shift_issue_queue_pkg;

  localparam int RB  = 1;
  localparam int PW  = 5 + RB;
  localparam int NPR = 32 * (1 << RB);
  localparam int DIW = 3 + 3*PW + 1 + 6 + 1;
  localparam int DW  = 3 + PW + 64 + 64 + 1;

  typedef struct packed {
    logic          sll;
    logic          srl;
    logic          sra;
    logic [PW-1:0] rd0;
    logic [PW-1:0] rs1;
    logic [PW-1:0] rs2;
    logic          rs2_is_imm;
    logic [5:0]    imm;
    logic          is32w;
  } dispat_info_t;

  typedef struct packed {
    logic          sll;
    logic          srl;
    logic          sra;
    logic [PW-1:0] rd0;
    logic [63:0]   op1;
    logic [63:0]   op2;
    logic          is32w;
  } exeparam_t;

  function automatic logic [63:0] imm_to_op2(input logic [5:0] imm);
    return {58'b0, imm};
  endfunction

endpackage

// File: rtl/gen_dffr.sv
// rtl/gen_dffr.sv - enabled register with asynchronous active-low clear
module gen_dffr #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/issue_fifo_ctrl.sv
// rtl/issue_fifo_ctrl.sv - circular-buffer pointers, occupancy and flush for issue queues
module issue_fifo_ctrl #(
  parameter int DP = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [$clog2(DP)-1:0] wr_ptr_o,
  output logic [$clog2(DP)-1:0] rd_ptr_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DP);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o   = (count_q == (AW+1)'(DP));
  assign empty_o  = (count_q == '0);
  assign push_ok  = push_i && !full_o;
  assign pop_ok   = pop_i && !empty_o;
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;

  // Flush overrides any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/shift_issue_queue.sv
// rtl/shift_issue_queue.sv - in-order issue queue launching shift micro-ops
// Entries hold only indices and the immediate; operand data is read at issue.
module shift_issue_queue
  import shift_issue_queue_pkg::*;
#(
  parameter int DP = 4
) (
  input  logic           CLK,
  input  logic           RSTn,
  input  logic           dispat_vaild,
  output logic           dispat_ready,
  input  logic [DIW-1:0] dispat_info,
  input  logic           flush,
  input  logic [NPR-1:0] regfile_ready,
  output logic [PW-1:0]  rs1_idx,
  output logic [PW-1:0]  rs2_idx,
  input  logic [63:0]    rs1_data,
  input  logic [63:0]    rs2_data,
  output logic           shift_exeparam_vaild,
  output logic [DW-1:0]  shift_exeparam
);

  localparam int AW = $clog2(DP);

  dispat_info_t  mem_q [DP];
  dispat_info_t  head;
  exeparam_t     launch;
  logic [DP-1:0] vld_q, vld_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, issue, launch_en;

  issue_fifo_ctrl #(.DP(DP)) u_ctrl (
    .clk_i    (CLK),
    .rst_n_i  (RSTn),
    .push_i   (push),
    .pop_i    (issue),
    .flush_i  (flush),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign dispat_ready = !full;
  assign push         = dispat_vaild && !full;
  assign head         = mem_q[rd_ptr];
  assign rs1_idx      = head.rs1;
  assign rs2_idx      = head.rs2;
  assign issue        = !empty && vld_q[rd_ptr] && regfile_ready[head.rs1]
                        && (head.rs2_is_imm || regfile_ready[head.rs2]);
  assign launch_en    = issue && !flush;

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr] <= dispat_info;
  end

  always_comb begin
    vld_d = vld_q;
    if (flush) begin
      vld_d = '0;
    end else begin
      if (push)  vld_d[wr_ptr] = 1'b1;
      if (issue) vld_d[rd_ptr] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  always_comb begin
    launch       = '0;
    launch.sll   = head.sll;
    launch.srl   = head.srl;
    launch.sra   = head.sra;
    launch.rd0   = head.rd0;
    launch.op1   = rs1_data;
    launch.op2   = head.rs2_is_imm ? imm_to_op2(head.imm) : rs2_data;
    launch.is32w = head.is32w;
  end

  // Payload only loads on a real launch so it holds through idle cycles.
  gen_dffr #(.W(DW)) u_param_reg (
    .clk_i   (CLK),
    .rst_n_i (RSTn),
    .en_i    (launch_en),
    .d_i     (launch),
    .q_o     (shift_exeparam)
  );

  gen_dffr #(.W(1)) u_vld_reg (
    .clk_i   (CLK),
    .rst_n_i (RSTn),
    .en_i    (1'b1),
    .d_i     (launch_en),
    .q_o     (shift_exeparam_vaild)
  );

endmodule

// File: tb/tb_shift_issue_queue.sv
// tb/tb_shift_issue_queue.sv - self-checking bench for shift_issue_queue
module tb_shift_issue_queue;

  localparam int DP  = 4;
  localparam int PW  = 6;
  localparam int NPR = 64;
  localparam int DIW = 29;
  localparam int DW  = 138;

  typedef struct {
    logic [2:0]    op;
    logic [PW-1:0] rd0, rs1, rs2;
    logic          imm_f;
    logic [5:0]    imm;
    logic          w;
  } uop_t;

  logic           CLK = 1'b0;
  logic           RSTn = 1'b1;
  logic           dispat_vaild = 1'b0;
  logic           flush = 1'b0;
  logic [DIW-1:0] dispat_info = '0;
  logic [NPR-1:0] regfile_ready = '0;
  logic [PW-1:0]  rs1_idx, rs2_idx;
  logic [63:0]    rs1_data, rs2_data;
  logic           dispat_ready, shift_exeparam_vaild;
  logic [DW-1:0]  shift_exeparam;
  logic [63:0]    rf [NPR];

  uop_t          q[$];
  uop_t          cur;
  logic [PW-1:0] launched[$];
  logic          exp_v;
  logic [DW-1:0] exp_p;
  int            n_chk = 0;
  int            n_fail = 0;

  always #5 CLK = ~CLK;

  assign rs1_data = rf[rs1_idx];
  assign rs2_data = rf[rs2_idx];

  shift_issue_queue #(.DP(DP)) dut (
    .CLK                  (CLK),
    .RSTn                 (RSTn),
    .dispat_vaild         (dispat_vaild),
    .dispat_ready         (dispat_ready),
    .dispat_info          (dispat_info),
    .flush                (flush),
    .regfile_ready        (regfile_ready),
    .rs1_idx              (rs1_idx),
    .rs2_idx              (rs2_idx),
    .rs1_data             (rs1_data),
    .rs2_data             (rs2_data),
    .shift_exeparam_vaild (shift_exeparam_vaild),
    .shift_exeparam       (shift_exeparam)
  );

  function automatic uop_t rnd_uop(input logic [PW-1:0] rd0);
    uop_t u;
    case ($urandom_range(0, 2))
      0:       u.op = 3'b100;
      1:       u.op = 3'b010;
      default: u.op = 3'b001;
    endcase
    u.rd0   = rd0;
    u.rs1   = PW'($urandom_range(0, NPR-1));
    u.rs2   = PW'($urandom_range(0, NPR-1));
    u.imm_f = 1'($urandom_range(0, 1));
    u.imm   = 6'($urandom);
    u.w     = 1'($urandom_range(0, 1));
    return u;
  endfunction

  task automatic offer(input uop_t u);
    cur          = u;
    dispat_info  = {u.op, u.rd0, u.rs1, u.rs2, u.imm_f, u.imm, u.w};
    dispat_vaild = 1'b1;
  endtask

  // One clock: predict from the queue model, advance, then compare.
  task automatic step(input string tag, output bit acc);
    bit   iss;
    uop_t h;
    logic [63:0] op2;
    acc = dispat_vaild && (q.size() < DP) && !flush;
    iss = (q.size() > 0) && regfile_ready[q[0].rs1] && (q[0].imm_f || regfile_ready[q[0].rs2]);
    n_chk++;
    if (dispat_ready !== (q.size() < DP)) begin
      n_fail++;
      $display("FAIL %s dispat_ready: got %b expected %b", tag, dispat_ready, q.size() < DP);
    end
    if (flush) begin
      q.delete();
      exp_v = 1'b0;
    end else begin
      if (iss) begin
        h     = q.pop_front();
        op2   = h.imm_f ? {58'b0, h.imm} : rf[h.rs2];
        exp_v = 1'b1;
        exp_p = {h.op, h.rd0, rf[h.rs1], op2, h.w};
        launched.push_back(h.rd0);
      end else begin
        exp_v = 1'b0;
      end
      if (acc) q.push_back(cur);
    end
    @(posedge CLK);
    #1;
    n_chk++;
    if (shift_exeparam_vaild !== exp_v) begin
      n_fail++;
      $display("FAIL %s exeparam_vaild: got %b expected %b", tag, shift_exeparam_vaild, exp_v);
    end
    n_chk++;
    if (shift_exeparam !== exp_p) begin
      n_fail++;
      $display("FAIL %s exeparam: got %h expected %h", tag, shift_exeparam, exp_p);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_v = 1'b0;
    exp_p = '0;
  endtask

  task automatic test_reset();
    #3 RSTn = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (shift_exeparam_vaild !== 1'b0 || shift_exeparam !== '0 || dispat_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: got v=%b p=%h rdy=%b expected v=0 p=0 rdy=1",
               shift_exeparam_vaild, shift_exeparam, dispat_ready);
    end
    @(posedge CLK); #1 RSTn = 1'b1;
  endtask

  task automatic test_sll_imm();
    uop_t u;
    bit   acc;
    u = rnd_uop(6'd5);
    u.op = 3'b100; u.rs1 = 6'd3; u.imm_f = 1'b1; u.imm = 6'd4; u.w = 1'b0;
    rf[3] = 64'h1;
    regfile_ready = '0;
    regfile_ready[3] = 1'b1;
    offer(u);
    step("sll_c1", acc);
    dispat_vaild = 1'b0;
    step("sll_c2", acc);
    n_chk++;
    if (shift_exeparam_vaild !== 1'b1 || shift_exeparam[64:1] !== 64'h4 ||
        shift_exeparam[128:65] !== 64'h1 || shift_exeparam[137] !== 1'b1) begin
      n_fail++;
      $display("FAIL sll_fields: got v=%b op1=%h op2=%h sll=%b expected v=1 op1=1 op2=4 sll=1",
               shift_exeparam_vaild, shift_exeparam[128:65], shift_exeparam[64:1], shift_exeparam[137]);
    end
  endtask

  task automatic test_in_order();
    uop_t a, b;
    bit   acc;
    launched.delete();
    regfile_ready = '0;
    regfile_ready[10] = 1'b1; regfile_ready[11] = 1'b1; regfile_ready[12] = 1'b1;
    a = rnd_uop(6'd20); a.op = 3'b001; a.rs1 = 6'd10; a.rs2 = 6'd7;  a.imm_f = 1'b0;
    b = rnd_uop(6'd21); b.op = 3'b010; b.rs1 = 6'd11; b.rs2 = 6'd12; b.imm_f = 1'b0;
    offer(a); step("ord_d0", acc);
    offer(b); step("ord_d1", acc);
    dispat_vaild = 1'b0;
    for (int i = 0; i < 4; i++) step("ord_wait", acc);
    regfile_ready[7] = 1'b1;
    for (int i = 0; i < 3; i++) step("ord_go", acc);
    n_chk++;
    if (launched.size() != 2 || launched[0] !== 6'd20 || launched[1] !== 6'd21) begin
      n_fail++;
      $display("FAIL ord_seq: got %0d launches expected 2 in order 20,21", launched.size());
    end
  endtask

  task automatic test_full();
    bit acc;
    bit got5;
    regfile_ready = '0;
    for (int i = 0; i < 4; i++) begin
      offer(rnd_uop(PW'(30 + i)));
      step("full_fill", acc);
    end
    offer(rnd_uop(6'd34));
    for (int i = 0; i < 3; i++) step("full_hold", acc);
    regfile_ready = '1;
    got5 = 1'b0;
    for (int i = 0; i < 10 && !got5; i++) begin
      step("full_drain", acc);
      got5 = acc;
    end
    dispat_vaild = 1'b0;
    n_chk++;
    if (!got5) begin
      n_fail++;
      $display("FAIL full_accept5: got not accepted expected accepted within 10 cycles");
    end
    for (int i = 0; i < 6; i++) step("full_tail", acc);
  endtask

  task automatic test_wrap();
    bit acc;
    launched.delete();
    regfile_ready = '1;
    for (int i = 1; i <= 10; i++) begin
      offer(rnd_uop(PW'(i)));
      acc = 1'b0;
      for (int k = 0; k < 8 && !acc; k++) step("wrap", acc);
      dispat_vaild = 1'b0;
      if (i % 2 == 0) step("wrap_gap", acc);
    end
    for (int i = 0; i < 4; i++) step("wrap_tail", acc);
    n_chk++;
    if (launched.size() != 10) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d expected 10", launched.size());
    end
    for (int i = 0; i < launched.size() && i < 10; i++) begin
      n_chk++;
      if (launched[i] !== PW'(i + 1)) begin
        n_fail++;
        $display("FAIL wrap_rd0[%0d]: got %0d expected %0d", i, launched[i], i + 1);
      end
    end
  endtask

  task automatic test_flush();
    bit acc;
    launched.delete();
    regfile_ready = '0;
    for (int i = 0; i < 3; i++) begin
      offer(rnd_uop(PW'(40 + i)));
      step("fl_fill", acc);
    end
    offer(rnd_uop(6'd43));
    regfile_ready = '1;
    flush = 1'b1;
    step("fl_cycle", acc);
    flush = 1'b0;
    dispat_vaild = 1'b0;
    n_chk++;
    if (dispat_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_ready: got %b expected 1", dispat_ready);
    end
    for (int i = 0; i < 5; i++) step("fl_after", acc);
    n_chk++;
    if (launched.size() != 0) begin
      n_fail++;
      $display("FAIL fl_stale: got %0d launches expected 0", launched.size());
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    regfile_ready = '0;
    for (int i = 0; i < 2; i++) begin
      offer(rnd_uop(PW'(50 + i)));
      step("rst_fill", acc);
    end
    dispat_vaild = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (shift_exeparam_vaild !== 1'b0 || shift_exeparam !== '0 || dispat_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b p=%h rdy=%b expected v=0 p=0 rdy=1",
               shift_exeparam_vaild, shift_exeparam, dispat_ready);
    end
    @(posedge CLK); #1 RSTn = 1'b1;
    regfile_ready = '1;
    for (int i = 0; i < 5; i++) step("rst_after", acc);
  endtask

  task automatic test_random();
    bit acc;
    bit pending;
    pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        offer(rnd_uop(PW'($urandom)));
        pending = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, NPR-1)] = {$urandom, $urandom};
      regfile_ready = {$urandom, $urandom} | {$urandom, $urandom};
      flush = ($urandom_range(0, 31) == 0);
      step("rand", acc);
      if (acc || flush) begin
        pending = 1'b0;
        dispat_vaild = 1'b0;
      end
      flush = 1'b0;
    end
    dispat_vaild = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NPR; i++) rf[i] = {$urandom, $urandom};
    model_reset();
    test_reset();
    test_sll_imm();
    test_in_order();
    test_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
